// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path (and the matching receiver).
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   // Clocks per bit; the caller must keep the result >= 2.
   function automatic int unsigned period_cycles(input int unsigned clock_speed,
                                                 input int unsigned baud_rate);
      return clock_speed / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable bit-period down-counter: load sets PERIOD_CYCLES-1, it then counts to 0 and holds.
module uart_baud_counter #(
   parameter int unsigned PERIOD_CYCLES = 10
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic load_in,
   output logic tc_out
);

   localparam int unsigned     CntW    = $clog2(PERIOD_CYCLES) + 1;
   localparam logic [CntW-1:0] LoadVal = CntW'(PERIOD_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_in) begin
         cnt_d = LoadVal;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_out = (cnt_q == '0);

endmodule

// File: rtl/uart_xmit.sv
// 8N1 UART transmitter with a one-byte holding buffer for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (odd when PARITY_ODD = 1) before the stop bit.
module uart_xmit
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned CLOCK_SPEED = 100_000_000,
   parameter bit          PARITY_ODD  = 1'b0
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic       ready_out,
   output logic       busy_out,
   output logic       tx_out,
   output logic [2:0] ustate
);

   localparam int unsigned PeriodCycles = period_cycles(CLOCK_SPEED, BAUD_RATE);
   localparam logic [2:0]  LastBit      = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t state_q, state_d;
   logic [7:0]     shift_q, shift_d, buf_q, buf_d, load_byte;
   logic [2:0]     bit_q, bit_d;
   logic           buf_full_q, buf_full_d, ready_q, tx_q, tx_d;
   logic           xfer, load, cnt_load, tc;

`ifdef UART_TX_PARITY_EN
   logic parity_q, parity_d;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   uart_baud_counter #(
      .PERIOD_CYCLES(PeriodCycles)
   ) u_baud (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .load_in (cnt_load),
      .tc_out  (tc)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      load       = 1'b0;
      xfer       = valid_in && ready_q;
      load_byte  = buf_full_q ? buf_q : data_in;

      unique case (state_q)
         IDLE: load = buf_full_q || xfer;
         START: begin
            if (tc) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tc) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tc) state_d = STOP;
`endif
         STOP: begin
            if (tc) begin
               load = buf_full_q || xfer;
               if (!load) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The buffered byte always goes first; otherwise an accepted byte bypasses the buffer.
      if (load) begin
         state_d = START;
         shift_d = load_byte;
         if (buf_full_q) buf_full_d = 1'b0;
      end
      if (xfer && !load) begin
         buf_d      = data_in;
         buf_full_d = 1'b1;
      end

`ifdef UART_TX_PARITY_EN
      parity_d = load ? ((^load_byte) ^ PARITY_ODD) : parity_q;
`endif

      // Line level is registered from the next state so tx_out never glitches.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = UART_IDLE_LEVEL;
      endcase
   end

   assign cnt_load = (state_d != IDLE) && (load || ((state_q != IDLE) && tc));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_q      <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         ready_q    <= 1'b0;
         tx_q       <= UART_IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         ready_q    <= !buf_full_d;
         tx_q       <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign ready_out = ready_q;
   assign busy_out  = (state_q != IDLE);
   assign tx_out    = tx_q;
   assign ustate    = state_q;

endmodule

// File: tb/tb_uart_xmit.sv
// Self-checking bench for uart_xmit: frame waveform model, back-to-back streams, reset abort
// and a behavioural receiver loopback with random bytes.
module tb_uart_xmit;

   localparam int unsigned ClockSpeed = 100_000_000;
   localparam int unsigned BaudRate   = 10_000_000;
   localparam int          P          = 10;
   localparam bit          ParityOdd  = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam int          FB         = 11;
`else
   localparam int          FB         = 10;
`endif
   localparam int          FP         = FB * P;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       ready, busy, tx;
   logic [2:0] ustate;

   int errors = 0;
   int checks = 0;

   logic [7:0] stream[$];
   logic [7:0] rx_q[$];
   int         frame_errs = 0;
   bit         mon_en     = 1'b0;

   always #5 clk = ~clk;

   uart_xmit #(
      .BAUD_RATE  (BaudRate),
      .CLOCK_SPEED(ClockSpeed),
      .PARITY_ODD (ParityOdd)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .valid_in (valid),
      .data_in  (data),
      .ready_out(ready),
      .busy_out (busy),
      .tx_out   (tx),
      .ustate   (ustate)
   );

   // Line level of bit slot j of the frame carrying byte b (slots past the frame are idle).
   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
      if (j == 9) return (^b) ^ ParityOdd;
`endif
      return 1'b1;
   endfunction

   function automatic logic [2:0] frame_state(input int j);
      if (j == 0) return 3'd1;
      if (j <= 8) return 3'd2;
      if (j == FB - 1) return 3'd4;
      if (j < FB - 1) return 3'd3;
      return 3'd0;
   endfunction

   // Edge (relative to the first transfer) at which byte i of a held-valid stream is taken.
   function automatic int acc_edge(input int i);
      return (i <= 1) ? i : (i - 1) * FP + 1;
   endfunction

   // Behavioural receiver: mid-bit sampling on the falling-edge clock.
   initial begin : monitor
      logic [7:0] b;
      logic       prev;
      bit         bad;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev && !tx) begin
            bad = 1'b0;
            repeat (P / 2) @(negedge clk);
            if (tx !== 1'b0) bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
               repeat (P) @(negedge clk);
               b[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (P) @(negedge clk);
            if (tx !== ((^b) ^ ParityOdd)) bad = 1'b1;
`endif
            repeat (P) @(negedge clk);
            if (tx !== 1'b1) bad = 1'b1;
            if (bad) frame_errs++;
            else rx_q.push_back(b);
         end
         prev = tx;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (ustate !== 3'd0) begin errors++; $display("FAIL reset_ustate: got %0d want 0", ustate); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx c%0d: got %b want 1", k, tx); end
         checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready c%0d: got %b want 1", k, ready); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d: got %b want 0", k, busy); end
         checks++; if (ustate !== 3'd0) begin errors++; $display("FAIL idle_ustate c%0d: got %0d want 0", k, ustate); end
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      int j;
      @(posedge clk); #1;
      valid = 1'b1;
      data  = b;
      @(posedge clk); #1;
      valid = 1'b0;
      data  = 8'($urandom);
      for (int k = 0; k < FP + 3; k++) begin
         @(negedge clk);
         j = k / P;
         checks++; if (tx !== frame_bit(b, j)) begin errors++;
            $display("FAIL single_tx %h c%0d: got %b want %b", b, k, tx, frame_bit(b, j)); end
         checks++; if (ustate !== frame_state(j)) begin errors++;
            $display("FAIL single_ustate %h c%0d: got %0d want %0d", b, k, ustate, frame_state(j)); end
         checks++; if (busy !== (k < FP)) begin errors++;
            $display("FAIL single_busy %h c%0d: got %b want %b", b, k, busy, (k < FP)); end
         checks++; if (ready !== 1'b1) begin errors++;
            $display("FAIL single_ready %h c%0d: got %b want 1", b, k, ready); end
      end
   endtask

   task automatic test_back_to_back();
      int         n;
      int         accepted;
      bit         buffered;
      logic       exp_tx;
      logic [2:0] exp_st;
      n = stream.size();
      @(posedge clk); #1;
      valid = 1'b1;
      data  = stream[0];
      @(posedge clk);
      accepted = 1;
      for (int k = 0; k < n * FP + 3; k++) begin
         #1;
         while (accepted < n && acc_edge(accepted) <= k) accepted++;
         valid = (accepted < n);
         data  = (accepted < n) ? stream[accepted] : 8'($urandom);
         buffered = 1'b0;
         for (int i = 1; i < n; i++) begin
            if (acc_edge(i) <= k && k < i * FP) buffered = 1'b1;
         end
         exp_tx = (k < n * FP) ? frame_bit(stream[k / FP], (k % FP) / P) : 1'b1;
         exp_st = (k < n * FP) ? frame_state((k % FP) / P) : 3'd0;
         @(negedge clk);
         checks++; if (tx !== exp_tx) begin errors++;
            $display("FAIL b2b_tx c%0d: got %b want %b", k, tx, exp_tx); end
         checks++; if (ustate !== exp_st) begin errors++;
            $display("FAIL b2b_ustate c%0d: got %0d want %0d", k, ustate, exp_st); end
         checks++; if (busy !== (k < n * FP)) begin errors++;
            $display("FAIL b2b_busy c%0d: got %b want %b", k, busy, (k < n * FP)); end
         checks++; if (ready !== !buffered) begin errors++;
            $display("FAIL b2b_ready c%0d: got %b want %b", k, ready, !buffered); end
         @(posedge clk);
      end
   endtask

   task automatic test_reset_abort();
      @(posedge clk); #1;
      valid = 1'b1;
      data  = 8'h0F;
      @(posedge clk); #1;
      data = 8'hC3;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (74) @(posedge clk);
      @(negedge clk);
      checks++; if (tx !== frame_bit(8'h0F, 7)) begin errors++;
         $display("FAIL abort_pre_tx: got %b want %b", tx, frame_bit(8'h0F, 7)); end
      checks++; if (ready !== 1'b0) begin errors++;
         $display("FAIL abort_pre_ready: got %b want 0", ready); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready); end
      checks++; if (ustate !== 3'd0) begin errors++; $display("FAIL abort_ustate: got %0d want 0", ustate); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready_release: got %b want 1", ready); end
      for (int k = 0; k < 3 * FP; k++) begin
         @(negedge clk);
         checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL abort_quiet c%0d: got tx=%b busy=%b want tx=1 busy=0", k, tx, busy); end
      end
   endtask

   task automatic test_loopback(input int n);
      logic [7:0] sent[$];
      logic [7:0] b;
      bit         ok;
      int         waited;
      rx_q.delete();
      frame_errs = 0;
      mon_en     = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            valid = 1'b0;
            repeat ($urandom_range(1, FP)) @(posedge clk);
            #1;
         end
         valid = 1'b1;
         data  = b;
         ok    = 1'b0;
         for (int w = 0; w < 3 * FP; w++) begin
            @(negedge clk);
            if (ready) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge clk); #1;
         valid = 1'b0;
         checks++; if (!ok) begin errors++; $display("FAIL loop_accept %0d: got ready=0 want 1", i); end
         if (ok) sent.push_back(b);
      end
      waited = 0;
      while (rx_q.size() + frame_errs < sent.size() && waited < 3 * FP) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (rx_q.size() != sent.size()) begin errors++;
         $display("FAIL loop_count: got %0d want %0d", rx_q.size(), sent.size()); end
      checks++; if (frame_errs != 0) begin errors++;
         $display("FAIL loop_framing: got %0d want 0", frame_errs); end
      for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
         checks++; if (rx_q[i] !== sent[i]) begin errors++;
            $display("FAIL loop_byte %0d: got %h want %h", i, rx_q[i], sent[i]); end
      end
      repeat (2 * P) @(posedge clk);
      mon_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single(8'hA5);
      test_single(8'h07);
      for (int i = 0; i < 3; i++) test_single(8'($urandom));
      stream = '{8'h00, 8'hFF, 8'h3C};
      test_back_to_back();
      stream.delete();
      for (int i = 0; i < 5; i++) stream.push_back(8'($urandom));
      test_back_to_back();
      test_reset_abort();
      test_loopback(40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
